// File: rtl/multicycle_add_sub.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, rippling the carry
// through a register. Produces NZCV flags once the last slice has been processed.
module multicycle_add_sub #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [1:0]       op,
    input  logic             carry_in,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    // state | meaning
    // IDLE  | waiting for in_valid; in_ready=1
    // RUN   | one slice per edge, slice index in k_q
    // DONE  | result/flags valid, held until out_ready

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              carry_q;
    logic [KW-1:0]     k_q;
    logic [WIDTH-1:0]  result_q;
    logic [3:0]        flags_q;

    logic              accept;
    logic              step;
    logic              last_step;
    logic              init_carry;

    int unsigned       chunk_lo;
    logic [CHUNK-1:0]  a_chunk;
    logic [CHUNK-1:0]  b_chunk;
    logic [CHUNK-1:0]  chunk_sum;
    logic              chunk_cout;
    logic              msb_cin;
    logic [WIDTH-1:0]  result_d;
    logic [3:0]        flags_d;

    assign accept    = (state_q == IDLE) && in_valid;
    assign step      = (state_q == RUN);
    assign last_step = step && (k_q == K_LAST);

    always_comb begin
        init_carry = carry_in;
        if (op == OP_ADD) begin
            init_carry = 1'b0;
        end else if (op == OP_SUB) begin
            init_carry = 1'b1;
        end
    end

    // Current slice: add, then splice into the running result
    always_comb begin
        chunk_lo = int'(k_q) * CHUNK;
        a_chunk  = a_q[chunk_lo +: CHUNK];
        b_chunk  = b_q[chunk_lo +: CHUNK];
        {chunk_cout, chunk_sum} = {1'b0, a_chunk} + {1'b0, b_chunk}
                                + {{CHUNK{1'b0}}, carry_q};
        // Carry into the slice MSB, recovered from the sum bit
        msb_cin  = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];
        result_d = result_q;
        result_d[chunk_lo +: CHUNK] = chunk_sum;
        flags_d  = {result_d[WIDTH-1], ~|result_d, chunk_cout, msb_cin ^ chunk_cout};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = RUN;
            RUN:  if (k_q == K_LAST) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q == RUN) || (state_q == DONE);
        out_valid = (state_q == DONE);
    end

    // B is stored pre-inverted for SUB/SBC so RUN is a plain add
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            k_q      <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else if (accept) begin
            a_q     <= a_in;
            b_q     <= op[0] ? ~b_in : b_in;
            carry_q <= init_carry;
            k_q     <= '0;
        end else if (step) begin
            result_q <= result_d;
            carry_q  <= chunk_cout;
            if (last_step) begin
                k_q     <= '0;
                flags_q <= flags_d;
            end else begin
                k_q <= k_q + KW'(1);
            end
        end
    end

    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_multicycle_add_sub.sv
// Self-checking bench for multicycle_add_sub: directed vector table, randomized ops
// against an arithmetic reference model, handshake and reset sequences.
module tb_multicycle_add_sub;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a_in;
    logic [63:0] b_in;
    logic [1:0]  op;
    logic        carry_in;
    logic [63:0] result;
    logic [3:0]  flags;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;

    multicycle_add_sub #(.WIDTH(64), .CHUNK(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .op        (op),
        .carry_in  (carry_in),
        .result    (result),
        .flags     (flags),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [1:0]  op;
        logic        ci;
        logic [63:0] r;
        logic [3:0]  f;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: full-width arithmetic, flags from sign/carry rules
    function automatic logic [67:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] o, input logic ci);
        logic [64:0] s;
        logic [63:0] bb;
        logic        c0;
        logic        v;
        bb = o[0] ? ~b : b;
        c0 = (o == 2'b00) ? 1'b0 : (o == 2'b01) ? 1'b1 : ci;
        s  = {1'b0, a} + {1'b0, bb} + {64'd0, c0};
        v  = (a[63] == bb[63]) && (s[63] != a[63]);
        return {s[63], (s[63:0] == 64'd0), s[64], v, s[63:0]};
    endfunction

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [1:0] o,
                          input logic ci, input logic [63:0] er, input logic [3:0] ef,
                          input int hold, input bit poke, input string nm);
        int cnt;
        a_in = a; b_in = b; op = o; carry_in = ci; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({nm, " accept rdy/busy/ov"}, {61'd0, in_ready, busy, out_valid}, 64'b010);
        if (poke) begin
            a_in = {$urandom, $urandom}; b_in = {$urandom, $urandom};
            op = 2'($urandom); carry_in = 1'($urandom); in_valid = 1'b1;
        end
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            if (poke) out_ready = (cnt < 3);
            @(posedge clk); #1;
            cnt++;
        end
        out_ready = 1'b0;
        chk({nm, " latency"}, 64'(cnt), 64'd4);
        chk({nm, " result"}, result, er);
        chk({nm, " flags"}, {60'd0, flags}, {60'd0, ef});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({nm, " hold result"}, result, er);
            chk({nm, " hold ov/rdy"}, {62'd0, out_valid, in_ready}, 64'b10);
        end
        // Handshake edge: a simultaneous in_valid must be ignored
        in_valid = 1'b1; out_ready = 1'b1;
        a_in = ~a; b_in = ~b;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk({nm, " release ov/rdy/busy"}, {61'd0, out_valid, in_ready, busy}, 64'b010);
        chk({nm, " retained result"}, result, er);
        chk({nm, " retained flags"}, {60'd0, flags}, {60'd0, ef});
    endtask

    initial begin
        logic [67:0] m;
        logic [63:0] ra;
        logic [63:0] rb;
        logic [1:0]  ro;
        logic        rc;
        bit          seen;

        vecs[0] = '{64'd54, 64'd17, 2'b01, 1'b0, 64'd37, 4'b0010};
        vecs[1] = '{64'd54, 64'hFFFF_FFFF_FFFF_FFEF, 2'b01, 1'b0, 64'd71, 4'b0000};
        vecs[2] = '{64'd10, 64'd17, 2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 4'b1000};
        vecs[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 1'b0, 64'h8000_0000_0000_0000, 4'b1001};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 1'b0, 64'd0, 4'b0110};
        vecs[5] = '{64'h0000_0000_0000_FFFF, 64'd1, 2'b10, 1'b1, 64'h0000_0000_0001_0001, 4'b0000};
        vecs[6] = '{64'd5, 64'd3, 2'b11, 1'b0, 64'd1, 4'b0010};
        vecs[7] = '{64'd0, 64'd0, 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000};
        vecs[8] = '{64'd0, 64'd0, 2'b00, 1'b1, 64'd0, 4'b0100};
        vecs[9] = '{64'h8000_0000_0000_0000, 64'd1, 2'b01, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a_in = '0; b_in = '0; op = 2'b00; carry_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ov/rdy/busy", {61'd0, out_valid, in_ready, busy}, 64'b010);
        chk("reset result", result, 64'd0);
        chk("reset flags", {60'd0, flags}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].ci, vecs[i].r, vecs[i].f,
                   (i == 0) ? 5 : 1, 1'b0, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: ra = 64'hFFFF_FFFF_FFFF_FFFF;
                1: rb = 64'h8000_0000_0000_0000;
                2: rb = ra;
                default: ;
            endcase
            ro = 2'($urandom);
            rc = 1'($urandom);
            m  = model(ra, rb, ro, rc);
            run_op(ra, rb, ro, rc, m[63:0], m[67:64], $urandom_range(0, 2), 1'b1,
                   $sformatf("rnd%0d", i));
        end

        // Reset while processing chunk 2
        a_in = 64'd54; b_in = 64'd17; op = 2'b01; carry_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst-run ov/rdy/busy", {61'd0, out_valid, in_ready, busy}, 64'b010);
        chk("rst-run result", result, 64'd0);
        chk("rst-run flags", {60'd0, flags}, 64'd0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        chk("in_valid during reset ignored", {63'd0, in_ready}, 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid || busy) seen = 1'b1;
        end
        chk("no ov after abort", {63'd0, seen}, 64'd0);

        // Reset while in DONE
        a_in = 64'd3; b_in = 64'd4; op = 2'b00; carry_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) begin
            @(posedge clk); #1;
        end
        chk("pre-rst done result", result, 64'd7);
        rst_n = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst-done ov/rdy/busy", {61'd0, out_valid, in_ready, busy}, 64'b010);
        chk("rst-done result", result, 64'd0);

        // Operation after reset recovery
        m = model(64'hDEAD_BEEF_0000_0001, 64'h0000_0001_FFFF_FFFF, 2'b01, 1'b0);
        run_op(64'hDEAD_BEEF_0000_0001, 64'h0000_0001_FFFF_FFFF, 2'b01, 1'b0,
               m[63:0], m[67:64], 2, 1'b0, "post-reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
